// File: rtl/matrix_scan_capture.sv
// Receive-side monitor for a row-scanned LED matrix: rebuilds 8x16 frames from the
// active-low one-hot row select and column data, commits clean frames to a snapshot.
module matrix_scan_capture #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ROWS-1:0]    dinor_in,
  input  logic [COLS-1:0]    outc_in,
  input  logic               hold,
  input  logic               clr_err,
  input  logic [2:0]         rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               err_multi,
  output logic               err_order,
  output logic               syncing
);

  localparam int RW = 3;
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  // Input stage: all decode works on these registered copies.
  logic [ROWS-1:0]  din_q;
  logic [COLS-1:0]  outc_q;

  state_t           state_q, state_d;
  logic [RW-1:0]    cur_row_q, cur_row_d;

  logic [COLS-1:0]  work_q [ROWS];
  logic [COLS-1:0]  snap_q [ROWS];

  logic [COLS-1:0]  rd_data_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             err_multi_q, err_multi_d;
  logic             err_order_q, err_order_d;
  logic             syncing_q;

  // Row decode
  logic [CW-1:0]    low_cnt;
  logic [RW-1:0]    dec_row;
  logic             is_blank;
  logic             is_valid;
  logic             is_multi;

  always_comb begin
    low_cnt = '0;
    dec_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!din_q[i]) begin
        low_cnt = low_cnt + CW'(1);
        dec_row = RW'(i);
      end
    end
  end

  assign is_blank = (low_cnt == CW'(0));
  assign is_valid = (low_cnt == CW'(1));
  assign is_multi = !is_blank && !is_valid;

  // FSM next-state and per-cycle actions
  logic             work_we;
  logic             commit;
  logic             set_multi;
  logic             set_order;
  logic [RW-1:0]    next_row;

  assign next_row = RW'(cur_row_q + RW'(1));

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    work_we   = 1'b0;
    commit    = 1'b0;
    set_multi = 1'b0;
    set_order = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (is_valid && dec_row == '0) begin
          state_d   = ST_CAPTURE;
          cur_row_d = '0;
          work_we   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (is_multi) begin
          set_multi = 1'b1;
          state_d   = ST_SYNC;
        end else if (is_valid) begin
          if (dec_row == cur_row_q) begin
            work_we = 1'b1;
          end else if (cur_row_q != LAST_ROW && dec_row == next_row) begin
            cur_row_d = dec_row;
            work_we   = 1'b1;
          end else if (dec_row == '0 && cur_row_q == LAST_ROW) begin
            // Frame boundary: the row-0 sample also opens the next frame.
            commit    = !hold;
            cur_row_d = '0;
            work_we   = 1'b1;
          end else begin
            set_order = 1'b1;
            state_d   = ST_SYNC;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // A new error wins over a simultaneous clear.
  assign err_multi_d = (err_multi_q && !clr_err) || set_multi;
  assign err_order_d = (err_order_q && !clr_err) || set_order;

  always_ff @(posedge clk) begin
    if (!rst) begin
      din_q        <= '1;
      outc_q       <= '0;
      state_q      <= ST_SYNC;
      cur_row_q    <= '0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_multi_q  <= 1'b0;
      err_order_q  <= 1'b0;
      syncing_q    <= 1'b1;
    end else begin
      din_q        <= dinor_in;
      outc_q       <= outc_in;
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      rd_data_q    <= snap_q[rd_row];
      frame_done_q <= commit;
      if (commit) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      err_multi_q  <= err_multi_d;
      err_order_q  <= err_order_d;
      syncing_q    <= (state_d == ST_SYNC);
    end
  end

  // A discarded partial frame needs no clearing: every row is rewritten before
  // the next commit can happen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        work_q[i] <= '0;
      end
    end else if (work_we) begin
      work_q[dec_row] <= outc_q;
    end
  end

  // Snapshot takes the work buffer as it stood before this edge's row-0 write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        snap_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < ROWS; i++) begin
        snap_q[i] <= work_q[i];
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_multi  = err_multi_q;
  assign err_order  = err_order_q;
  assign syncing    = syncing_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Bench for matrix_scan_capture: random scans checked against a frame-level
// reference model that tracks sync, expected next row and buffers as plain arrays.
module tb_matrix_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dinor_in;
  logic [15:0] outc_in;
  logic        hold;
  logic        clr_err;
  logic [2:0]  rd_row;
  logic [15:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_multi;
  logic        err_order;
  logic        syncing;

  matrix_scan_capture #(.ROWS(8), .COLS(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .dinor_in   (dinor_in),
    .outc_in    (outc_in),
    .hold       (hold),
    .clr_err    (clr_err),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_multi  (err_multi),
    .err_order  (err_order),
    .syncing    (syncing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  bit          m_synced = 0;
  int          m_row = 0;
  logic [15:0] m_work [8];
  logic [15:0] m_snap [8];
  int          m_cnt = 0;
  bit          m_emulti = 0;
  bit          m_eorder = 0;
  bit          m_done = 0;
  logic [15:0] m_rd = '0;
  logic [7:0]  m_din_r = 8'hFF;
  logic [15:0] m_outc_r = '0;
  int          dut_pulses = 0;
  int          mdl_pulses = 0;
  logic [15:0] fr [8];

  // Advances the model by one clock edge using the pins present at that edge.
  task automatic model_edge();
    int zeros;
    int r;
    if (!rst) begin
      m_synced = 0; m_row = 0; m_cnt = 0; m_emulti = 0; m_eorder = 0;
      m_done = 0; m_rd = '0; m_din_r = 8'hFF; m_outc_r = '0;
      for (int i = 0; i < 8; i++) begin m_work[i] = '0; m_snap[i] = '0; end
      return;
    end
    m_rd = m_snap[rd_row];
    m_done = 0;
    if (clr_err) begin m_emulti = 0; m_eorder = 0; end
    zeros = $countones(~m_din_r);
    r = 0;
    for (int i = 0; i < 8; i++) if (!m_din_r[i]) r = i;
    if (!m_synced) begin
      if (zeros == 1 && r == 0) begin m_synced = 1; m_row = 0; m_work[0] = m_outc_r; end
    end else if (zeros > 1) begin
      m_emulti = 1; m_synced = 0;
    end else if (zeros == 1) begin
      if (r == m_row) m_work[r] = m_outc_r;
      else if (r == m_row + 1) begin m_row = r; m_work[r] = m_outc_r; end
      else if (r == 0 && m_row == 7) begin
        if (!hold) begin
          for (int i = 0; i < 8; i++) m_snap[i] = m_work[i];
          m_done = 1;
          m_cnt = (m_cnt + 1) % 65536;
        end
        m_row = 0; m_work[0] = m_outc_r;
      end else begin
        m_eorder = 1; m_synced = 0;
      end
    end
    m_din_r = dinor_in;
    m_outc_r = outc_in;
  endtask

  task automatic cyc(input logic [7:0] din, input logic [15:0] outc);
    dinor_in = din;
    outc_in  = outc;
    @(posedge clk);
    model_edge();
    #1;
    if (frame_done === 1'b1) dut_pulses++;
    if (m_done) mdl_pulses++;
  endtask

  task automatic send_row(input int r, input logic [15:0] data, input int dwell, input int blank);
    logic [7:0] sel;
    sel = 8'h01 << r;
    for (int i = 0; i < dwell; i++) cyc(~sel, data);
    for (int i = 0; i < blank; i++) cyc(8'hFF, 16'($urandom));
  endtask

  // Rows 0..7 from fr[], then a row 0 carrying nxt that closes the frame.
  task automatic send_frame(input int dwell_max, input int blank_max, input logic [15:0] nxt);
    for (int r = 0; r < 8; r++)
      send_row(r, fr[r], $urandom_range(dwell_max, 1), $urandom_range(blank_max, 0));
    send_row(0, nxt, $urandom_range(dwell_max, 1), 2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(8'hFF, 16'h0000);
    cyc(8'h00, 16'hFFFF);
    if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++;
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++;
    if ({err_multi, err_order} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", err_multi, err_order); end
    checks++;
    if (syncing !== 1'b1) begin errors++; $display("FAIL reset_syncing: got %b expected 1", syncing); end
    checks++;
    rst = 1'b1;
    cyc(8'hFF, 16'h0);
  endtask

  task automatic test_clean_frame();
    int p0;
    p0 = dut_pulses;
    for (int r = 0; r < 8; r++) fr[r] = 16'h0100 << r;
    for (int r = 0; r < 8; r++) send_row(r, fr[r], 3, 0);
    send_row(0, fr[0], 3, 2);
    if (dut_pulses - p0 !== 1) begin errors++; $display("FAIL clean_pulses: got %0d expected 1", dut_pulses - p0); end
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL clean_cnt: got %0d expected 1", frame_cnt); end
    checks++;
    if (syncing !== 1'b0) begin errors++; $display("FAIL clean_syncing: got %b expected 0", syncing); end
    checks++;
    rd_row = 3'd3;
    cyc(8'hFF, 16'h0);
    if (rd_data !== 16'h0800) begin errors++; $display("FAIL clean_rd3: got %h expected 0800", rd_data); end
    checks++;
    if (rd_data !== m_rd) begin errors++; $display("FAIL clean_rd3_model: got %h expected %h", rd_data, m_rd); end
    checks++;
  endtask

  task automatic test_order_error();
    int p0;
    int c0;
    p0 = dut_pulses;
    send_row(0, 16'h1111, 2, 0);
    send_row(1, 16'h2222, 2, 0);
    send_row(3, 16'h3333, 2, 2);
    if (err_order !== 1'b1) begin errors++; $display("FAIL order_flag: got %b expected 1", err_order); end
    checks++;
    if (syncing !== 1'b1) begin errors++; $display("FAIL order_syncing: got %b expected 1", syncing); end
    checks++;
    if (dut_pulses !== p0) begin errors++; $display("FAIL order_no_pulse: got %0d expected %0d", dut_pulses, p0); end
    checks++;
    c0 = m_cnt;
    for (int r = 0; r < 8; r++) fr[r] = 16'($urandom);
    send_frame(3, 0, 16'($urandom));
    if (frame_cnt !== 16'(c0 + 1) || frame_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL order_recover_cnt: got %0d expected %0d", frame_cnt, c0 + 1);
    end
    checks++;
    clr_err = 1'b1;
    cyc(8'hFF, 16'h0);
    clr_err = 1'b0;
    cyc(8'hFF, 16'h0);
    if (err_order !== 1'b0) begin errors++; $display("FAIL order_clear: got %b expected 0", err_order); end
    checks++;
  endtask

  task automatic test_multi();
    send_row(0, 16'hA0A0, 2, 0);
    send_row(1, 16'hA1A1, 2, 0);
    send_row(2, 16'hA2A2, 2, 0);
    cyc(8'b11110011, 16'hDEAD);
    cyc(8'hFF, 16'h0);
    cyc(8'hFF, 16'h0);
    if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b expected 1", err_multi); end
    checks++;
    if (syncing !== 1'b1) begin errors++; $display("FAIL multi_syncing: got %b expected 1", syncing); end
    checks++;
    clr_err = 1'b1;
    cyc(8'hFF, 16'h0);
    clr_err = 1'b0;
    if (err_multi !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b expected 0", err_multi); end
    checks++;
    send_row(0, 16'hB0B0, 2, 0);
    send_row(1, 16'hB1B1, 2, 0);
    cyc(8'b00111111, 16'hBEEF);
    // Clear lands on the same edge the registered multi-select is decoded.
    clr_err = 1'b1;
    cyc(8'hFF, 16'h0);
    clr_err = 1'b0;
    cyc(8'hFF, 16'h0);
    if (err_multi !== 1'b1 || err_multi !== m_emulti) begin
      errors++; $display("FAIL multi_clr_collision: got %b expected 1", err_multi);
    end
    checks++;
    clr_err = 1'b1;
    cyc(8'hFF, 16'h0);
    clr_err = 1'b0;
  endtask

  task automatic test_blanking();
    int p0;
    p0 = dut_pulses;
    for (int r = 0; r < 8; r++) fr[r] = 16'($urandom);
    for (int r = 0; r < 8; r++) send_row(r, fr[r], $urandom_range(3, 1), 2);
    send_row(0, 16'($urandom), 2, 2);
    if (dut_pulses - p0 !== 1 || mdl_pulses !== dut_pulses) begin
      errors++; $display("FAIL blank_pulses: got %0d expected 1", dut_pulses - p0);
    end
    checks++;
    if ({err_multi, err_order} !== 2'b00) begin errors++; $display("FAIL blank_errs: got %b%b expected 00", err_multi, err_order); end
    checks++;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      cyc(8'hFF, 16'h0);
      if (rd_data !== fr[r]) begin errors++; $display("FAIL blank_row%0d: got %h expected %h", r, rd_data, fr[r]); end
      checks++;
    end
  endtask

  task automatic test_hold();
    logic [15:0] old [8];
    int c0;
    int p0;
    for (int r = 0; r < 8; r++) old[r] = fr[r];
    c0 = m_cnt;
    p0 = dut_pulses;
    hold = 1'b1;
    for (int r = 0; r < 8; r++) fr[r] = 16'($urandom);
    send_frame(2, 1, 16'($urandom));
    if (dut_pulses !== p0) begin errors++; $display("FAIL hold_no_pulse: got %0d expected %0d", dut_pulses, p0); end
    checks++;
    if (frame_cnt !== 16'(c0)) begin errors++; $display("FAIL hold_cnt: got %0d expected %0d", frame_cnt, c0); end
    checks++;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      cyc(8'hFF, 16'h0);
      if (rd_data !== old[r]) begin errors++; $display("FAIL hold_old_row%0d: got %h expected %h", r, rd_data, old[r]); end
      checks++;
    end
    hold = 1'b0;
    for (int r = 0; r < 8; r++) fr[r] = 16'($urandom);
    send_frame(2, 1, 16'($urandom));
    if (frame_cnt !== 16'(c0 + 1)) begin errors++; $display("FAIL hold_release_cnt: got %0d expected %0d", frame_cnt, c0 + 1); end
    checks++;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      cyc(8'hFF, 16'h0);
      if (rd_data !== fr[r]) begin errors++; $display("FAIL hold_new_row%0d: got %h expected %h", r, rd_data, fr[r]); end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = dut_pulses;
    for (int f = 0; f < 6; f++) begin
      hold = ($urandom_range(3, 0) == 0);
      for (int r = 0; r < 8; r++) fr[r] = 16'($urandom);
      for (int r = 0; r < 8; r++) send_row(r, fr[r], 1, $urandom_range(1, 0));
    end
    send_row(0, 16'($urandom), 1, 2);
    hold = 1'b0;
    if (dut_pulses - p0 !== mdl_pulses - p0 + (dut_pulses - mdl_pulses) || dut_pulses !== mdl_pulses) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected %0d", dut_pulses, mdl_pulses);
    end
    checks++;
    if (frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt, m_cnt); end
    checks++;
    if ({err_multi, err_order} !== 2'b00) begin errors++; $display("FAIL b2b_errs: got %b%b expected 00", err_multi, err_order); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      rd_row = 3'($urandom_range(7, 0));
      cyc(8'hFF, 16'h0);
      if (rd_data !== m_rd) begin errors++; $display("FAIL b2b_read%0d: got %h expected %h", i, rd_data, m_rd); end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 4; r++) send_row(r, 16'($urandom), 2, 0);
    send_row(4, 16'h4444, 1, 0);
    rst = 1'b0;
    cyc(~8'h10, 16'h4444);
    rst = 1'b1;
    if ({rd_data, frame_done, frame_cnt} !== 33'd0) begin
      errors++; $display("FAIL rstmid_outs: got rd=%h done=%b cnt=%0d expected 0", rd_data, frame_done, frame_cnt);
    end
    checks++;
    if ({err_multi, err_order, syncing} !== 3'b001) begin
      errors++; $display("FAIL rstmid_flags: got %b%b%b expected 001", err_multi, err_order, syncing);
    end
    checks++;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      cyc(~8'h10, 16'h5555);
      if (rd_data !== 16'h0) begin errors++; $display("FAIL rstmid_row%0d: got %h expected 0000", r, rd_data); end
      checks++;
    end
    if (syncing !== 1'b1) begin errors++; $display("FAIL rstmid_syncing: got %b expected 1", syncing); end
    checks++;
  endtask

  initial begin
    rst = 1'b0; dinor_in = 8'hFF; outc_in = '0;
    hold = 1'b0; clr_err = 1'b0; rd_row = '0;
    test_reset();
    test_clean_frame();
    test_order_error();
    test_multi();
    test_blanking();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
